// File: rtl/pipelined_carry_select_adder_pkg.sv
// pipelined_carry_select_adder_pkg: shared arithmetic constants and slice record
//   WIDTH_D      default operand width
//   SLICE_D      default bits resolved per pipeline stage
//   slice_rec_t  conditional slice sums/carries {s0, s1, c0, c1}
package pipelined_carry_select_adder_pkg;
    localparam int WIDTH_D = 16;
    localparam int SLICE_D = 4;
    typedef struct packed {
        logic [SLICE_D-1:0] s0;
        logic [SLICE_D-1:0] s1;
        logic               c0;
        logic               c1;
    } slice_rec_t;
endpackage

// File: rtl/pipelined_carry_select_adder_csa_slice.sv
// csa_slice: conditional sums of one slice for carry-in 0 and carry-in 1
//   a, b    slice operands
//   s0, c0  sum and carry out assuming carry-in 0
//   s1, c1  sum and carry out assuming carry-in 1
module csa_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] s0,
    output logic             c0,
    output logic [SLICE-1:0] s1,
    output logic             c1
);
    assign {c0, s0} = {1'b0, a} + {1'b0, b};
    assign {c1, s1} = {1'b0, a} + {1'b0, b} + (SLICE+1)'(1);
endmodule

// File: rtl/pipelined_carry_select_adder.sv
// pipelined_carry_select_adder: elastic carry-select adder, one slice resolved per stage
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_ready    operand handshake
//   a, b, cin             operands and carry in
//   out_valid, out_ready  result handshake
//   sum, cout, overflow   a + b + cin, unsigned carry out, signed overflow
module pipelined_carry_select_adder
    import pipelined_carry_select_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int SLICE = SLICE_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NSTG = WIDTH / SLICE;

    slice_rec_t [NSTG-1:0] pre;
    logic                  v  [NSTG];
    logic [WIDTH-1:0]      r  [NSTG];
    logic                  c  [NSTG];
    slice_rec_t [NSTG-1:0] q  [NSTG];
    logic                  am [NSTG];
    logic                  bm [NSTG];
    logic [NSTG:0]         ld;

    for (genvar j = 0; j < NSTG; j++) begin : g_pre
        csa_slice #(.SLICE(SLICE)) u_slice (
            .a  (a[j*SLICE +: SLICE]),
            .b  (b[j*SLICE +: SLICE]),
            .s0 (pre[j].s0),
            .c0 (pre[j].c0),
            .s1 (pre[j].s1),
            .c1 (pre[j].c1)
        );
    end

    // A stage can load if it is empty or everything downstream of it moves,
    // so ready ripples back combinationally from out_ready.
    always_comb begin
        ld[NSTG] = out_ready;
        for (int k = NSTG - 1; k >= 0; k--)
            ld[k] = ~v[k] | ld[k+1];
    end

    assign in_ready = ld[0] & ~rst;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic                  pv;
        logic                  pc;
        logic [SLICE-1:0]      ps;
        logic [WIDTH-1:0]      pr;
        slice_rec_t [NSTG-1:0] pq;
        logic                  pa;
        logic                  pb;
        if (k == 0) begin : g_in
            assign pv = in_valid & in_ready;
            assign ps = cin ? pre[0].s1 : pre[0].s0;
            assign pc = cin ? pre[0].c1 : pre[0].c0;
            assign pr = '0;
            assign pq = pre;
            assign pa = a[WIDTH-1];
            assign pb = b[WIDTH-1];
        end else begin : g_mid
            assign pv = v[k-1];
            assign ps = c[k-1] ? q[k-1][k].s1 : q[k-1][k].s0;
            assign pc = c[k-1] ? q[k-1][k].c1 : q[k-1][k].c0;
            assign pr = r[k-1];
            assign pq = q[k-1];
            assign pa = am[k-1];
            assign pb = bm[k-1];
        end
        // Data only moves with a valid token, so a stalled or drained last
        // stage keeps its result on the outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                v[k]  <= 1'b0;
                r[k]  <= '0;
                c[k]  <= 1'b0;
                q[k]  <= '0;
                am[k] <= 1'b0;
                bm[k] <= 1'b0;
            end else if (ld[k]) begin
                v[k] <= pv;
                if (pv) begin
                    r[k]  <= pr | (WIDTH'(ps) << (SLICE * k));
                    c[k]  <= pc;
                    q[k]  <= pq;
                    am[k] <= pa;
                    bm[k] <= pb;
                end
            end
        end
    end

    assign out_valid = v[NSTG-1];
    assign sum       = r[NSTG-1];
    assign cout      = c[NSTG-1];
    assign overflow  = (am[NSTG-1] == bm[NSTG-1]) & (sum[WIDTH-1] != am[NSTG-1]);
endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// tb_pipelined_carry_select_adder: directed table-driven bench for the pipelined adder
module tb_pipelined_carry_select_adder;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    vec_t tv [8];
    int   total = 0;
    int   bad   = 0;

    pipelined_carry_select_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int i);
        a   = tv[i].a;
        b   = tv[i].b;
        cin = tv[i].cin;
    endtask

    task automatic chk_out(input string nm, input int i);
        chk({nm, "_sum"}, 32'(sum), 32'(tv[i].s));
        chk({nm, "_cout"}, 32'(cout), 32'(tv[i].co));
        chk({nm, "_ovf"}, 32'(overflow), 32'(tv[i].ov));
    endtask

    task automatic run_one(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                           input logic [15:0] es, input logic eco, input logic eov);
        int n;
        a = xa; b = xb; cin = xc; in_valid = 1'b1;
        chk("one_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("one_latency", 32'(n), 32'd3);
        chk("one_sum", 32'(sum), 32'(es));
        chk("one_cout", 32'(cout), 32'(eco));
        chk("one_ovf", 32'(overflow), 32'(eov));
        @(posedge clk); #1;
        chk("one_drain", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int idx;
        int oi;
        tv[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tv[3] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        tv[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tv[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tv[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tv[7] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_sum", 32'(sum), 32'd0);
        chk("post_rst_cout", 32'(cout), 32'd0);
        chk("post_rst_ovf", 32'(overflow), 32'd0);

        for (int i = 0; i < 8; i++)
            run_one(tv[i].a, tv[i].b, tv[i].cin, tv[i].s, tv[i].co, tv[i].ov);

        out_ready = 1'b1;
        for (int e = 0; e < 12; e++) begin
            in_valid = (e < 8);
            if (e < 8) drive(e);
            #1;
            if (e < 8) chk("b2b_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            chk("b2b_valid", 32'(out_valid), 32'(e >= 3 && e <= 10));
            if (e >= 3 && e <= 10) chk_out("b2b", e - 3);
        end
        in_valid = 1'b0;

        idx = 0; oi = 0;
        for (int cyc = 0; cyc < 40 && oi < 6; cyc++) begin
            out_ready = (cyc >= 8);
            in_valid = (idx < 6);
            drive(idx < 6 ? idx : 0);
            #1;
            if (cyc >= 4 && cyc <= 7) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                chk_out("stall_hold", 0);
            end
            if (cyc == 7) chk("stall_accepted", 32'(idx), 32'd4);
            if (cyc == 8) chk("passthru_in_ready", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                chk_out("drain", oi);
                oi++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        chk("drain_count", 32'(oi), 32'd6);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_empty", 32'(out_valid), 32'd0);

        for (int i = 0; i < 3; i++) begin
            drive(i);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive(3);
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("midrst_out_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        run_one(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
